// File: rtl/trig_align_pkg.sv
// Shared types and helpers for the trigger phase-alignment block:
// lock/lane state encodings and the one-hot phase flag decoder.
package trig_align_pkg;

    localparam int PHASE_W = 3;
    localparam int BIN_W   = 2;

    typedef enum logic {
        SEARCH,
        LOCKED
    } lock_state_t;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        DEAD
    } lane_state_t;

    typedef struct packed {
        logic               valid;
        logic [PHASE_W-1:0] index;
    } onehot_idx_t;

    // valid only when exactly one flag is set; index is that flag's position
    function automatic onehot_idx_t onehot8_index(input logic [7:0] flags);
        onehot_idx_t res;
        int          ones;
        res.valid = 1'b0;
        res.index = '0;
        ones      = 0;
        for (int k = 0; k < 8; k++) begin
            if (flags[k]) begin
                ones      = ones + 1;
                res.index = PHASE_W'(k);
            end
        end
        res.valid = (ones == 1);
        return res;
    endfunction

endpackage

// File: rtl/trig_lane_shaper.sv
// One trigger lane: turns an accepted edge into a fixed-width pulse followed
// by a dead-time hold-off before the lane can accept again.
module trig_lane_shaper
    import trig_align_pkg::*;
(
    input  logic       clk_adc,
    input  logic       rst,
    input  logic       arm,
    input  logic       src,
    input  logic [7:0] firingticks,
    input  logic [7:0] deadticks,
    output logic       accept,
    output logic       trig
);

    lane_state_t state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;

    always_ff @(posedge clk_adc) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = arm & src & (state_reg == IDLE);
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = FIRE;
                    // a zero width still yields a single-cycle pulse
                    cnt_next   = (firingticks == 8'd0) ? 8'd1 : firingticks;
                end
            end
            FIRE: begin
                if (cnt_reg == 8'd1) begin
                    state_next = (deadticks == 8'd0) ? IDLE : DEAD;
                    cnt_next   = deadticks;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            DEAD: begin
                if (cnt_reg == 8'd1) begin
                    state_next = IDLE;
                end
                cnt_next = cnt_reg - 8'd1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign trig = (state_reg == FIRE);

endmodule

// File: rtl/trig_phase_align.sv
// Locks onto the sampling edge/bin reported by the calibration windows and
// shapes the selected coax lanes into aligned, width-controlled trigger pulses.
module trig_phase_align
    import trig_align_pkg::*;
#(
    parameter int NCH          = 16,
    parameter int LOCK_WINDOWS = 2
) (
    input  logic               clk_adc,
    input  logic               rst,
    input  logic [NCH-1:0]     coax_in,
    input  logic [NCH-1:0]     coax_neg,
    input  logic               spareright,
    input  logic [7:0]         delaycounter,
    input  logic [7:0]         firingticks,
    input  logic [7:0]         deadticks,
    output logic [NCH-1:0]     trig_out,
    output logic               locked,
    output logic [PHASE_W-1:0] phase,
    output logic [7:0]         relock_count,
    output logic [15:0]        trig_count
);

    localparam int AGREE_W = $clog2(LOCK_WINDOWS + 1);

    logic                 spareright_q_reg;
    logic [BIN_W-1:0]     bin_reg;
    lock_state_t          lock_state_reg, lock_state_next;
    logic [PHASE_W-1:0]   cand_reg, cand_next;
    logic [AGREE_W-1:0]   agree_reg, agree_next;
    logic [PHASE_W-1:0]   phase_reg, phase_next;
    logic [7:0]           relock_reg, relock_next;
    logic [15:0]          trig_count_reg;

    logic                 win_close;
    logic [7:0]           win_flags;
    onehot_idx_t          win;
    logic                 arm;
    logic [NCH-1:0]       src;
    logic [NCH-1:0]       accept_vec;
    logic [15:0]          accept_count;

    // the flags are taken on the falling edge of the calibration window
    assign win_close = spareright_q_reg & ~spareright;
    assign win_flags = delaycounter;
    assign win       = onehot8_index(win_flags);

    always_ff @(posedge clk_adc) begin
        if (rst) begin
            spareright_q_reg <= 1'b0;
            bin_reg          <= '0;
            lock_state_reg   <= SEARCH;
            cand_reg         <= '0;
            agree_reg        <= '0;
            phase_reg        <= '0;
            relock_reg       <= '0;
            trig_count_reg   <= '0;
        end else begin
            spareright_q_reg <= spareright;
            bin_reg          <= bin_reg + BIN_W'(1);
            lock_state_reg   <= lock_state_next;
            cand_reg         <= cand_next;
            agree_reg        <= agree_next;
            phase_reg        <= phase_next;
            relock_reg       <= relock_next;
            trig_count_reg   <= trig_count_reg + accept_count;
        end
    end

    always_comb begin
        lock_state_next = lock_state_reg;
        cand_next       = cand_reg;
        agree_next      = agree_reg;
        phase_next      = phase_reg;
        relock_next     = relock_reg;
        if (win_close) begin
            case (lock_state_reg)
                SEARCH: begin
                    if (!win.valid) begin
                        agree_next = '0;
                    end else if (win.index == cand_reg) begin
                        agree_next = agree_reg + AGREE_W'(1);
                    end else begin
                        cand_next  = win.index;
                        agree_next = AGREE_W'(1);
                    end
                    if (agree_next == AGREE_W'(LOCK_WINDOWS)) begin
                        lock_state_next = LOCKED;
                        phase_next      = cand_next;
                        agree_next      = '0;
                    end
                end
                LOCKED: begin
                    // invalid windows leave the tracking state untouched
                    if (win.valid) begin
                        if (win.index == phase_reg) begin
                            agree_next = '0;
                        end else begin
                            if (win.index == cand_reg) begin
                                agree_next = agree_reg + AGREE_W'(1);
                            end else begin
                                cand_next  = win.index;
                                agree_next = AGREE_W'(1);
                            end
                            if (agree_next == AGREE_W'(LOCK_WINDOWS)) begin
                                phase_next  = cand_next;
                                agree_next  = '0;
                                relock_next = (relock_reg == 8'hFF) ? relock_reg
                                                                    : relock_reg + 8'd1;
                            end
                        end
                    end
                end
                default: begin
                    lock_state_next = SEARCH;
                end
            endcase
        end
    end

    assign arm = (lock_state_reg == LOCKED) & ~spareright & (bin_reg == phase_reg[1:0]);
    assign src = phase_reg[2] ? coax_neg : coax_in;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
            trig_lane_shaper u_lane (
                .clk_adc     (clk_adc),
                .rst         (rst),
                .arm         (arm),
                .src         (src[gi]),
                .firingticks (firingticks),
                .deadticks   (deadticks),
                .accept      (accept_vec[gi]),
                .trig        (trig_out[gi])
            );
        end
    endgenerate

    always_comb begin
        accept_count = '0;
        for (int k = 0; k < NCH; k++) begin
            accept_count = accept_count + 16'(accept_vec[k]);
        end
    end

    assign locked       = (lock_state_reg == LOCKED);
    assign phase        = phase_reg;
    assign relock_count = relock_reg;
    assign trig_count   = trig_count_reg;

endmodule
